// File: rtl/cdc_acct_feeder.sv
// Generic circular FIFO holding whole records; occupancy count kept alongside the pointers.
// Latency: a pushed entry is visible at head on the cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module acct_fifo #(
   parameter int WIDTH = 24,
   parameter int ASIZE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [ASIZE:0]   cnt,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 2 ** ASIZE;
   localparam logic [ASIZE:0] CNT_FULL = {1'b1, {ASIZE{1'b0}}};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [ASIZE-1:0] wptr;
   logic [ASIZE-1:0] rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNT_FULL);
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= push_dat;
      end
   end

   // Pointers wrap naturally at DEPTH; the count moves only on unpaired push or pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + ASIZE'(1);
         end
         if (do_pop) begin
            rptr <= rptr + ASIZE'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (ASIZE+1)'(1);
            2'b01:   cnt <= cnt - (ASIZE+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// Host-loaded record buffer that issues single-cycle beats to the CDC account channel.
// Latency: push into empty FIFO with ready held -> in_valid 2 cycles after the push edge.
// Backpressure: ld_ready drops when the FIFO is full; beats wait in ARM until ready is seen.
module cdc_acct_feeder #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 3,
   parameter int GAP   = 2,
   parameter int CSIZE = 16
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [DSIZE-1:0] ld_account,
   input  logic [DSIZE-1:0] ld_A,
   input  logic [DSIZE-1:0] ld_T,
   input  logic             ready,
   output logic             in_valid,
   output logic [DSIZE-1:0] in_account,
   output logic [DSIZE-1:0] in_A,
   output logic [DSIZE-1:0] in_T,
   output logic [ASIZE:0]   fifo_cnt,
   output logic [CSIZE-1:0] sent_cnt
);

   typedef struct packed {
      logic [DSIZE-1:0] account;
      logic [DSIZE-1:0] A;
      logic [DSIZE-1:0] T;
   } rec_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_SEND,
      S_GAP
   } state_t;

   // Gap counter is loaded with GAP-1 so that exactly GAP cycles are spent in S_GAP.
   localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   rec_t       ld_rec;
   rec_t       head_rec;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;
   state_t     state;
   logic [3:0] gap_cnt;

   assign ld_rec   = '{account: ld_account, A: ld_A, T: ld_T};
   assign ld_ready = !fifo_full;
   // ARM is only entered with a non-empty FIFO, so a pop here always has data.
   assign pop      = (state == S_ARM) && ready;

   acct_fifo #(
      .WIDTH ($bits(rec_t)),
      .ASIZE (ASIZE)
   ) u_fifo (
      .clk      (clk1),
      .rst_n    (rst_n),
      .push     (ld_valid),
      .push_dat (ld_rec),
      .pop      (pop),
      .head     (head_rec),
      .cnt      (fifo_cnt),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Issue FSM: output registers default to an idle, zeroed beat every cycle.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         gap_cnt    <= '0;
         in_valid   <= 1'b0;
         in_account <= '0;
         in_A       <= '0;
         in_T       <= '0;
         sent_cnt   <= '0;
      end else begin
         in_valid   <= 1'b0;
         in_account <= '0;
         in_A       <= '0;
         in_T       <= '0;
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  state <= S_ARM;
               end
            end
            S_ARM: begin
               // The beat is committed on the ready sample; a later drop of ready does not cancel it.
               if (ready) begin
                  state      <= S_SEND;
                  in_valid   <= 1'b1;
                  in_account <= head_rec.account;
                  in_A       <= head_rec.A;
                  in_T       <= head_rec.T;
               end
            end
            S_SEND: begin
               sent_cnt <= sent_cnt + CSIZE'(1);
               if (GAP > 0) begin
                  state   <= S_GAP;
                  gap_cnt <= GAP_LD;
               end else begin
                  state <= fifo_empty ? S_IDLE : S_ARM;
               end
            end
            S_GAP: begin
               if (gap_cnt == 4'd0) begin
                  state <= fifo_empty ? S_IDLE : S_ARM;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_acct_feeder.sv
// Directed bench for cdc_acct_feeder: reset, latency, throttling, full FIFO, wrap, mid-gap reset.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: pushes are counted only when ld_ready was high at the driving edge.
module tb_cdc_acct_feeder;

   localparam int DSIZE = 8;
   localparam int ASIZE = 3;
   localparam int GAP   = 2;
   localparam int CSIZE = 16;

   logic             clk1 = 1'b0;
   logic             rst_n;
   logic             ld_valid;
   logic             ld_ready;
   logic [DSIZE-1:0] ld_account;
   logic [DSIZE-1:0] ld_A;
   logic [DSIZE-1:0] ld_T;
   logic             ready;
   logic             in_valid;
   logic [DSIZE-1:0] in_account;
   logic [DSIZE-1:0] in_A;
   logic [DSIZE-1:0] in_T;
   logic [ASIZE:0]   fifo_cnt;
   logic [CSIZE-1:0] sent_cnt;

   int vectors     = 0;
   int miscompares = 0;

   logic [23:0] got [$];
   logic [23:0] exp_q [$];
   int cyc_n     = 0;
   int last_beat = -100;
   int gap_viol  = 0;
   int zero_viol = 0;
   int max_cnt   = 0;

   always #5 clk1 = ~clk1;

   cdc_acct_feeder #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE),
      .GAP   (GAP),
      .CSIZE (CSIZE)
   ) dut (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_account (ld_account),
      .ld_A       (ld_A),
      .ld_T       (ld_T),
      .ready      (ready),
      .in_valid   (in_valid),
      .in_account (in_account),
      .in_A       (in_A),
      .in_T       (in_T),
      .fifo_cnt   (fifo_cnt),
      .sent_cnt   (sent_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] got_at(input int k);
      if (k < got.size()) return got[k];
      return 24'hFFFFFF;
   endfunction

   // One clock: wait for the falling edge, then log any beat and track spacing/occupancy.
   task automatic cyc();
      @(negedge clk1);
      cyc_n++;
      if (in_valid === 1'b1) begin
         got.push_back({in_account, in_A, in_T});
         if (cyc_n - last_beat < GAP + 1) gap_viol++;
         last_beat = cyc_n;
      end else if (in_valid === 1'b0 && {in_account, in_A, in_T} !== 24'd0) begin
         zero_viol++;
      end
      if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      ld_valid = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      got.delete();
      exp_q.delete();
      last_beat = -100;
      gap_viol  = 0;
      zero_viol = 0;
      max_cnt   = 0;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] x, input logic [7:0] t);
      ld_valid   = 1'b1;
      ld_account = a;
      ld_A       = x;
      ld_T       = t;
      cyc();
      ld_valid = 1'b0;
   endtask

   task automatic check_seq(input string tag);
      check({tag, " count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         check($sformatf("%s rec%0d", tag, k), 32'(got_at(k)), 32'(exp_q[k]));
      end
   endtask

   initial begin
      int sent_i;
      int t;
      int w;
      int n0;
      logic acc;

      // Reset with garbage on the load port
      rst_n      = 1'b0;
      ld_valid   = 1'b1;
      ld_account = 8'hAA;
      ld_A       = 8'h55;
      ld_T       = 8'h33;
      ready      = 1'b1;
      cycles(3);
      check("rst fifo_cnt", 32'(fifo_cnt), 0);
      check("rst ld_ready", 32'(ld_ready), 1);
      check("rst in_valid", 32'(in_valid), 0);
      check("rst in_account", 32'(in_account), 0);
      check("rst in_A", 32'(in_A), 0);
      check("rst in_T", 32'(in_T), 0);
      check("rst sent_cnt", 32'(sent_cnt), 0);

      // Single record, ready held: beat two edges after the push edge
      do_reset();
      ready = 1'b1;
      push(8'd167, 8'd5, 8'd9);
      check("single lat0 in_valid", 32'(in_valid), 0);
      check("single lat0 fifo_cnt", 32'(fifo_cnt), 1);
      cyc();
      check("single lat1 in_valid", 32'(in_valid), 0);
      cyc();
      check("single lat2 in_valid", 32'(in_valid), 1);
      check("single in_account", 32'(in_account), 167);
      check("single in_A", 32'(in_A), 5);
      check("single in_T", 32'(in_T), 9);
      check("single fifo_cnt after pop", 32'(fifo_cnt), 0);
      cyc();
      check("single pulse width", 32'(in_valid), 0);
      check("single sent_cnt", 32'(sent_cnt), 1);
      cycles(6);
      check("single beat count", 32'(got.size()), 1);
      check("single sent_cnt final", 32'(sent_cnt), 1);

      // Ready throttling: nothing leaves while ready is low
      do_reset();
      ready = 1'b0;
      push(8'd167, 8'd1, 8'd2);
      push(8'd231, 8'd3, 8'd4);
      push(8'd68,  8'd5, 8'd6);
      exp_q.push_back({8'd167, 8'd1, 8'd2});
      exp_q.push_back({8'd231, 8'd3, 8'd4});
      exp_q.push_back({8'd68,  8'd5, 8'd6});
      cycles(4);
      check("throttle fifo_cnt", 32'(fifo_cnt), 3);
      check("throttle no beats", 32'(got.size()), 0);
      ready = 1'b1;
      cycles(20);
      check_seq("throttle");
      check("throttle sent_cnt", 32'(sent_cnt), 3);
      check("throttle gap", 32'(gap_viol), 0);
      check("throttle idle zero", 32'(zero_viol), 0);
      check("throttle drained", 32'(fifo_cnt), 0);

      // Full FIFO: IDs 9 and 10 are refused
      do_reset();
      ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         check($sformatf("full ld_ready id%0d", i), 32'(ld_ready), (i <= 8) ? 1 : 0);
         push(8'(i), 8'(i + 100), 8'(i + 200));
         if (i <= 8) exp_q.push_back({8'(i), 8'(i + 100), 8'(i + 200)});
      end
      check("full fifo_cnt", 32'(fifo_cnt), 8);
      ready = 1'b1;
      cycles(45);
      check_seq("full");
      check("full sent_cnt", 32'(sent_cnt), 8);
      check("full gap", 32'(gap_viol), 0);

      // Continuous load, ready toggling every 5 cycles, pointers wrap twice
      do_reset();
      sent_i = 0;
      t      = 0;
      for (int k = 0; k < 20; k++) exp_q.push_back({8'(k + 50), 8'(k * 3), 8'(255 - k)});
      while ((sent_i < 20 || got.size() < 20) && t < 600) begin
         ready    = ((t / 5) % 2 == 0);
         ld_valid = (sent_i < 20);
         if (sent_i < 20) begin
            ld_account = 8'(sent_i + 50);
            ld_A       = 8'(sent_i * 3);
            ld_T       = 8'(255 - sent_i);
         end
         acc = ld_valid && ld_ready;
         cyc();
         if (acc) sent_i++;
         t++;
      end
      ld_valid = 1'b0;
      cycles(4);
      check("stream accepted", 32'(sent_i), 20);
      check_seq("stream");
      check("stream max fifo_cnt", 32'(max_cnt), 8);
      check("stream sent_cnt", 32'(sent_cnt), 20);
      check("stream gap", 32'(gap_viol), 0);
      check("stream idle zero", 32'(zero_viol), 0);

      // Reset during a gap discards the backlog
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'(i + 10), 8'(i), 8'(i));
      ready = 1'b1;
      w = 0;
      while (in_valid !== 1'b1 && w < 20) begin
         cyc();
         w++;
      end
      check("midrst beat seen", 32'(in_valid), 1);
      check("midrst first id", 32'(in_account), 10);
      cyc();
      check("midrst cnt before rst", 32'(fifo_cnt), 4);
      rst_n = 1'b0;
      cyc();
      check("midrst in_valid", 32'(in_valid), 0);
      check("midrst fifo_cnt", 32'(fifo_cnt), 0);
      check("midrst ld_ready", 32'(ld_ready), 1);
      check("midrst sent_cnt", 32'(sent_cnt), 0);
      rst_n = 1'b1;
      n0 = got.size();
      cycles(20);
      check("midrst no stale beats", 32'(got.size()), 32'(n0));
      push(8'd77, 8'd7, 8'd8);
      cycles(2);
      check("midrst new beat", 32'(in_valid), 1);
      check("midrst new id", 32'(in_account), 77);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
